duck_palette_arbiter: RTL and testbench
=======================================

# duck_palette_arbiter

Shares one 16-entry duck sprite palette lookup between N sprite pixel requesters using round-robin arbitration. Each accepted 4-bit index produces a registered 12-bit RGB result, a transparency flag and the requester ID, one cycle later. The block sits between the sprite engines and the pixel compositor in front of VGA output. It replaces per-sprite palette copies.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ID_W, $clog2(N_REQ), width of requester tag
- KEY_RGB, 12'hAEA, chroma-key colour reported as transparent
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  requester i has an index pending
- req_index  in  N_REQ*4  packed indices, requester i at [4i+3:4i]
- req_ready  out  N_REQ  one-hot or zero; requester i's index is accepted this cycle
- out_valid  out  1  result register holds a valid pixel
- out_ready  in  1  compositor consumes result this cycle
- out_id  out  ID_W  requester that produced the result
- out_rgb  out  12  {red, green, blue}, 4 bits each
- out_transparent  out  1  out_rgb == KEY_RGB

## Operation
- Reset (Reset_n low, asynchronous): out_valid=0, out_id=0, out_rgb=0, out_transparent=0, rr_ptr=0. req_ready is 0 while in reset.
- advance = !out_valid || out_ready.
- Grant: scan requesters starting at rr_ptr, wrapping modulo N_REQ. The first i with req_valid[i] is granted.
- req_ready[i] = advance && grant[i]. This is combinational from req_valid, rr_ptr, out_valid and out_ready. req_ready never depends on req_index.
- Transfer on req_valid[i] && req_ready[i]:
  - out_valid<=1, out_id<=i.
  - out_rgb<=palette[req_index[i]].
  - out_transparent<=(palette[req_index[i]]==KEY_RGB).
  - rr_ptr<=(i+1) mod N_REQ.
- If advance is true and no requester is valid: out_valid<=0. out_id and out_rgb hold their last values. rr_ptr holds.
- If out_valid && !out_ready: everything holds and all req_ready=0. Stalled output data must not change.
- rr_ptr moves only on a transfer, so no requester is starved. A continuously valid requester is served at least once every N_REQ transfers.
- Requesters must hold req_valid and req_index stable until accepted. The arbiter does not check this.
- Palette contents, index→RGB:
  - 0→F76, 1→AEA, 2→A01, 3→FFF, 4→000
  - 5→050, 6→050, 7..15→AEA
- Transparent indices are 1 and 7..15.

## Timing
- Latency: one cycle from the transfer edge to out_valid/out_rgb.
- Throughput: one pixel per cycle while out_ready=1 and any req_valid=1.
- Simultaneous pop and push: out_ready=1 with out_valid=1 and a grant loads the new pixel in the same edge, with no bubble.
- rr_ptr wraps from N_REQ-1 to 0.
- Reset asserted mid-stream discards the in-flight result. out_valid drops immediately, without waiting for Clk.
- After Reset_n deasserts, the first grant uses priority order 0,1,2,…

## Structure
- Shared package duck_pkg:
  - typedef rgb12_t (logic [11:0])
  - constant KEY_RGB_DEFAULT = 12'hAEA
  - palette index typedef pal_idx_t (logic [3:0])
- Sub-module rr_pick: a combinational round-robin priority picker. Inputs are the request vector and pointer; outputs are a one-hot grant and the binary index.
- The existing duck palette module is instantiated once as the combinational lookup on the granted index. The index is muxed from req_index before the output register.
- The top level holds the output register, rr_ptr and the advance logic.

## Test plan
- Reset check: Reset_n=0 asserted mid-stream → out_valid=0, out_rgb=0 and req_ready=0 in the same cycle. After release with req_valid=4'b1111, req_ready=4'b0001.
- Single requester: req_valid=4'b0100, index 2 → next cycle out_valid=1, out_id=2, out_rgb=A01, out_transparent=0.
- Round-robin with all four valid, indices {0,3,4,5}, out_ready=1:
  - Grants occur in order 0,1,2,3,0 on consecutive cycles.
  - Outputs are F76, FFF, 000, 050, F76 with no gaps.
- Backpressure: out_ready=0 for 3 cycles with out_valid=1 → req_ready=0. out_rgb and out_id are held unchanged and rr_ptr does not advance. When out_ready returns to 1, the next grant proceeds at the original rr_ptr.
- Transparency: index 1 → out_rgb=AEA, out_transparent=1. Index 9 → AEA, out_transparent=1. Index 6 → 050, out_transparent=0.
- Drain: a single valid pixel, then all req_valid=0 with out_ready=1 → out_valid drops to 0 one cycle after consumption. rr_ptr is unchanged.

Source files
------------

// File: rtl/duck_pkg.sv
// Shared types and constants for the duck sprite palette path.
package duck_pkg;

    typedef logic [11:0] rgb12_t;
    typedef logic [3:0]  pal_idx_t;

    localparam rgb12_t KEY_RGB_DEFAULT = 12'hAEA;

endpackage

// File: rtl/duck_palette.sv
// Combinational 16-entry duck sprite palette: 4-bit index to 12-bit {R,G,B}.
module duck_palette
    import duck_pkg::*;
(
    input  pal_idx_t idx_i,
    output rgb12_t   rgb_o
);

    // Fixed palette ROM; unused slots read as the chroma key so they render transparent.
    always_comb begin
        rgb_o = KEY_RGB_DEFAULT;
        case (idx_i)
            4'd0:    rgb_o = 12'hF76;
            4'd1:    rgb_o = 12'hAEA;
            4'd2:    rgb_o = 12'hA01;
            4'd3:    rgb_o = 12'hFFF;
            4'd4:    rgb_o = 12'h000;
            4'd5:    rgb_o = 12'h050;
            4'd6:    rgb_o = 12'h050;
            default: rgb_o = KEY_RGB_DEFAULT;
        endcase
    end

endmodule

// File: rtl/duck_palette_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_o
);

    // Walk N_REQ positions from the pointer; the first hit wins.
    always_comb begin
        int p;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        p       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            p = int'(ptr_i) + k;
            p = (p >= N_REQ) ? (p - N_REQ) : p;
            if (!any_o && req_i[p]) begin
                any_o      = 1'b1;
                grant_o[p] = 1'b1;
                idx_o      = p[ID_W-1:0];
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/duck_palette_arbiter.sv
// Round-robin shared palette lookup for N sprite requesters with a one-deep
// registered result stage and ready/valid flow control on both sides.
module duck_palette_arbiter
    import duck_pkg::*;
#(
    parameter int     N_REQ   = 4,
    parameter int     ID_W    = $clog2(N_REQ),
    parameter rgb12_t KEY_RGB = KEY_RGB_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*4-1:0]   req_index,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_W-1:0]      out_id,
    output logic [11:0]          out_rgb,
    output logic                 out_transparent
);

    logic              out_valid_q, out_valid_d;
    logic [ID_W-1:0]   out_id_q,    out_id_d;
    rgb12_t            out_rgb_q,   out_rgb_d;
    logic              out_tr_q,    out_tr_d;
    logic [ID_W-1:0]   rr_ptr_q,    rr_ptr_d;

    logic              advance_s;
    logic              any_s;
    logic              transfer_s;
    logic [N_REQ-1:0]  grant_s;
    logic [ID_W-1:0]   gidx_s;
    pal_idx_t          sel_idx_s;
    rgb12_t            pal_rgb_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (gidx_s),
        .any_o   (any_s)
    );

    assign sel_idx_s = req_index[{gidx_s, 2'b00} +: 4];

    duck_palette u_palette (
        .idx_i (sel_idx_s),
        .rgb_o (pal_rgb_s)
    );

    // The result slot can take a new pixel when empty or being drained this cycle.
    assign advance_s  = !out_valid_q || out_ready;
    assign transfer_s = Reset_n && advance_s && any_s;
    // Gated by Reset_n so no requester sees an accept while reset is held.
    assign req_ready  = (Reset_n && advance_s) ? grant_s : {N_REQ{1'b0}};

    // Next-state: load on transfer, empty on an idle advance, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_rgb_d   = out_rgb_q;
        out_tr_d    = out_tr_q;
        rr_ptr_d    = rr_ptr_q;
        if (transfer_s) begin
            out_valid_d = 1'b1;
            out_id_d    = gidx_s;
            out_rgb_d   = pal_rgb_s;
            out_tr_d    = (pal_rgb_s == KEY_RGB);
            rr_ptr_d    = (gidx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (gidx_s + 1'b1);
        end else if (advance_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Result register and round-robin pointer.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            out_id_q    <= {ID_W{1'b0}};
            out_rgb_q   <= 12'h000;
            out_tr_q    <= 1'b0;
            rr_ptr_q    <= {ID_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_rgb_q   <= out_rgb_d;
            out_tr_q    <= out_tr_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_id          = out_id_q;
    assign out_rgb         = out_rgb_q;
    assign out_transparent = out_tr_q;

endmodule

// File: tb/tb_duck_palette_arbiter.sv
// Directed table-driven bench for duck_palette_arbiter (N_REQ=4).
module tb_duck_palette_arbiter;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  req_valid;
    logic [15:0] req_index;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_id;
    logic [11:0] out_rgb;
    logic        out_transparent;

    int n_vec;
    int n_bad;

    duck_palette_arbiter #(.N_REQ(4)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_id          (out_id),
        .out_rgb         (out_rgb),
        .out_transparent (out_transparent)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] idx;
        logic        ord;
        logic [3:0]  rdy;
        logic        ov;
        logic [1:0]  id;
        logic [11:0] rgb;
        logic        tr;
    } vec_t;

    vec_t tbl [21];

    task automatic check(input string name, input int tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step%0d: got %h expected %h", name, tag, got, exp);
        end
    endtask

    initial begin
        // single requester 2, then drain
        tbl[0]  = '{4'b0100, 16'h0200, 1'b1, 4'b0100, 1'b1, 2'd2, 12'hA01, 1'b0};
        tbl[1]  = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd2, 12'hA01, 1'b0};
        // bring pointer back to 0 via requester 3, index 6
        tbl[2]  = '{4'b1000, 16'h6000, 1'b1, 4'b1000, 1'b1, 2'd3, 12'h050, 1'b0};
        // all four valid, indices {5,4,3,0}: grants 0,1,2,3,0
        tbl[3]  = '{4'b1111, 16'h5430, 1'b1, 4'b0001, 1'b1, 2'd0, 12'hF76, 1'b0};
        tbl[4]  = '{4'b1111, 16'h5430, 1'b1, 4'b0010, 1'b1, 2'd1, 12'hFFF, 1'b0};
        tbl[5]  = '{4'b1111, 16'h5430, 1'b1, 4'b0100, 1'b1, 2'd2, 12'h000, 1'b0};
        tbl[6]  = '{4'b1111, 16'h5430, 1'b1, 4'b1000, 1'b1, 2'd3, 12'h050, 1'b0};
        tbl[7]  = '{4'b1111, 16'h5430, 1'b1, 4'b0001, 1'b1, 2'd0, 12'hF76, 1'b0};
        // backpressure for 3 cycles, then resume at pointer 1
        tbl[8]  = '{4'b1111, 16'h5430, 1'b0, 4'b0000, 1'b1, 2'd0, 12'hF76, 1'b0};
        tbl[9]  = '{4'b1111, 16'h5430, 1'b0, 4'b0000, 1'b1, 2'd0, 12'hF76, 1'b0};
        tbl[10] = '{4'b1111, 16'h5430, 1'b0, 4'b0000, 1'b1, 2'd0, 12'hF76, 1'b0};
        tbl[11] = '{4'b1111, 16'h5430, 1'b1, 4'b0010, 1'b1, 2'd1, 12'hFFF, 1'b0};
        // transparency: index 1, index 9, index 6
        tbl[12] = '{4'b0001, 16'h0001, 1'b1, 4'b0001, 1'b1, 2'd0, 12'hAEA, 1'b1};
        tbl[13] = '{4'b0010, 16'h0090, 1'b1, 4'b0010, 1'b1, 2'd1, 12'hAEA, 1'b1};
        tbl[14] = '{4'b0100, 16'h0600, 1'b1, 4'b0100, 1'b1, 2'd2, 12'h050, 1'b0};
        // drain: valid drops, data and pointer hold
        tbl[15] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd2, 12'h050, 1'b0};
        tbl[16] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 2'd2, 12'h050, 1'b0};
        // pointer still 3 after drain
        tbl[17] = '{4'b1111, 16'h5430, 1'b1, 4'b1000, 1'b1, 2'd3, 12'h050, 1'b0};
        // stalled output ignores new requests
        tbl[18] = '{4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd3, 12'h050, 1'b0};
        tbl[19] = '{4'b0010, 16'h0030, 1'b0, 4'b0000, 1'b1, 2'd3, 12'h050, 1'b0};
        tbl[20] = '{4'b0010, 16'h0030, 1'b1, 4'b0010, 1'b1, 2'd1, 12'hFFF, 1'b0};

        n_vec     = 0;
        n_bad     = 0;
        Reset_n   = 1'b0;
        req_valid = 4'b0000;
        req_index = 16'h0000;
        out_ready = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_valid", -1, {15'd0, out_valid}, 16'h0000);
        check("rst_rgb",   -1, {4'd0, out_rgb}, 16'h0000);
        check("rst_id",    -1, {14'd0, out_id}, 16'h0000);
        check("rst_tr",    -1, {15'd0, out_transparent}, 16'h0000);
        req_valid = 4'b1111;
        #1;
        check("rst_ready", -1, {12'd0, req_ready}, 16'h0000);
        req_valid = 4'b0000;

        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            @(negedge Clk);
            req_valid = tbl[i].v;
            req_index = tbl[i].idx;
            out_ready = tbl[i].ord;
            #1;
            check("req_ready", i, {12'd0, req_ready}, {12'd0, tbl[i].rdy});
            @(posedge Clk);
            #1;
            check("out_valid", i, {15'd0, out_valid}, {15'd0, tbl[i].ov});
            check("out_id",    i, {14'd0, out_id}, {14'd0, tbl[i].id});
            check("out_rgb",   i, {4'd0, out_rgb}, {4'd0, tbl[i].rgb});
            check("out_tr",    i, {15'd0, out_transparent}, {15'd0, tbl[i].tr});
        end

        // mid-stream reset: out_valid is 1 here; reset must clear without a clock edge
        @(negedge Clk);
        req_valid = 4'b1111;
        req_index = 16'h5430;
        out_ready = 1'b0;
        #1;
        Reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 100, {15'd0, out_valid}, 16'h0000);
        check("mid_rst_rgb",   100, {4'd0, out_rgb}, 16'h0000);
        check("mid_rst_id",    100, {14'd0, out_id}, 16'h0000);
        check("mid_rst_ready", 100, {12'd0, req_ready}, 16'h0000);
        @(posedge Clk);
        #1;
        check("mid_rst_hold", 101, {15'd0, out_valid}, 16'h0000);

        @(negedge Clk);
        Reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 102, {12'd0, req_ready}, 16'h0001);
        @(posedge Clk);
        #1;
        check("post_rst_valid", 102, {15'd0, out_valid}, 16'h0001);
        check("post_rst_id",    102, {14'd0, out_id}, 16'h0000);
        check("post_rst_rgb",   102, {4'd0, out_rgb}, 16'h0F76);
        @(negedge Clk);
        #1;
        check("post_rst_next", 103, {12'd0, req_ready}, 16'h0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
